// File: rtl/l2_responder_if.sv
// Shared-bus request/response and backing-memory signals of the L2 responder.
interface l2_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              L2_start;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              L2_done;
    logic [DATA_W-1:0] rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  L2_start, req_addr, req_we, req_wdata, mem_ack, mem_rdata,
        output L2_done, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output L2_start, req_addr, req_we, req_wdata, mem_ack, mem_rdata,
        input  L2_done, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_responder.sv
// Direct-mapped write-through L2 responder with 4-phase start/done handshake.
// Optional read hit/miss counters are enabled by defining L2_STATS_EN.
module l2_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_responder_if.slave    bus
`ifdef L2_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);
    localparam int TAG_W  = ADDR_W - IDX_W;
    localparam int NLINES = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_MEM_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state, w_nxt_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;

    logic              r_done, w_nxt_done;
    logic [DATA_W-1:0] r_rdata, w_nxt_rdata;
    logic              r_mem_req, w_nxt_mem_req;
    logic              r_mem_we, w_nxt_mem_we;
    logic [ADDR_W-1:0] r_mem_addr, w_nxt_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_nxt_mem_wdata;

    logic [NLINES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag  [NLINES];
    logic [DATA_W-1:0] r_data [NLINES];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_fill;
    logic              w_upd;

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_rdata     = r_rdata;
        w_nxt_mem_req   = r_mem_req;
        w_nxt_mem_we    = r_mem_we;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        w_fill          = 1'b0;
        w_upd           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.L2_start) w_nxt_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we) begin
                    w_nxt_mem_req   = 1'b1;
                    w_nxt_mem_we    = 1'b1;
                    w_nxt_mem_addr  = r_addr;
                    w_nxt_mem_wdata = r_wdata;
                    w_nxt_state     = S_MEM_WR;
                end else if (w_hit) begin
                    w_nxt_rdata = r_data[w_idx];
                    w_nxt_state = S_DONE;
                end else begin
                    w_nxt_mem_req  = 1'b1;
                    w_nxt_mem_we   = 1'b0;
                    w_nxt_mem_addr = r_addr;
                    w_nxt_state    = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (bus.mem_ack) begin
                    w_nxt_mem_req = 1'b0;
                    w_nxt_rdata   = bus.mem_rdata;
                    w_fill        = 1'b1;
                    w_nxt_state   = S_DONE;
                end
            end
            S_MEM_WR: begin
                // Write-through without allocate: only a resident line is refreshed.
                if (bus.mem_ack) begin
                    w_nxt_mem_req = 1'b0;
                    w_nxt_mem_we  = 1'b0;
                    w_upd         = w_hit;
                    w_nxt_state   = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.L2_start) w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state     = S_IDLE;
                w_nxt_rdata     = '0;
                w_nxt_mem_req   = 1'b0;
                w_nxt_mem_we    = 1'b0;
                w_nxt_mem_addr  = '0;
                w_nxt_mem_wdata = '0;
            end
        endcase
        w_nxt_done = (w_nxt_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_valid     <= '0;
        end else begin
            r_done      <= w_nxt_done;
            r_rdata     <= w_nxt_rdata;
            r_mem_req   <= w_nxt_mem_req;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            if (r_state == S_IDLE && bus.L2_start) begin
                r_addr  <= bus.req_addr;
                r_we    <= bus.req_we;
                r_wdata <= bus.req_wdata;
            end
            if (w_fill) r_valid[w_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (w_fill || w_upd) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_fill ? bus.mem_rdata : r_wdata;
        end
    end

`ifdef L2_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP && !r_we) begin
            if (w_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            if (!w_hit && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

    assign bus.L2_done   = r_done;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_l2_responder.sv
// Scoreboard bench for l2_responder: reference model tracks resident addresses and memory contents.
module tb_l2_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef L2_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    l2_responder #(.ADDR_W(8), .DATA_W(8), .IDX_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef L2_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    typedef struct {
        logic       is_read;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wdata;
    } mx_t;

    int   total = 0;
    int   bad   = 0;
    sb_t  sb_q[$];
    mx_t  mx_q[$];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int   resident [4];
    int   mem_lat_cfg = 3;
    logic [7:0] last_rdata;
    int   n_hit, n_miss;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (resident[i]) resident[i] = -1;
        last_rdata = 8'h00;
        n_hit  = 0;
        n_miss = 0;
    endfunction

    // Reference behaviour: read data always equals memory (write-through); a read
    // hits only if its exact address is resident in its slot; writes never allocate.
    function automatic void model_issue(input logic [7:0] addr, input logic we,
                                        input logic [7:0] wdata, output logic hit);
        sb_t e;
        mx_t m;
        int  idx;
        idx = int'(addr) % 4;
        hit = 1'b0;
        e.is_read = !we;
        e.data    = 8'h00;
        if (!we) begin
            hit = (resident[idx] == int'(addr));
            if (hit) n_hit++;
            else begin
                n_miss++;
                resident[idx] = int'(addr);
                m.addr = addr; m.we = 1'b0; m.wdata = 8'h00;
                mx_q.push_back(m);
            end
            e.data     = ref_mem[addr];
            last_rdata = ref_mem[addr];
        end else begin
            m.addr = addr; m.we = 1'b1; m.wdata = wdata;
            mx_q.push_back(m);
            ref_mem[addr] = wdata;
        end
        sb_q.push_back(e);
    endfunction

    // Full 4-phase request; called and returning on a negedge.
    task automatic do_req(input logic [7:0] addr, input logic we, input logic [7:0] wdata, input int hold);
        logic hit, got, held;
        int   cyc, exp_lat;
        model_issue(addr, we, wdata, hit);
        exp_lat = hit ? 2 : 3 + mem_lat_cfg;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        bus.L2_start  = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                bus.req_addr  = 8'($urandom);
                bus.req_we    = 1'($urandom);
                bus.req_wdata = 8'($urandom);
            end
            got = bus.L2_done;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", cyc, exp_lat);
        held = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            held &= bus.L2_done;
        end
        check("done_held", 32'(held), 32'd1);
        check("rdata_held", 32'(bus.rdata), 32'(last_rdata));
        bus.L2_start = 1'b0;
        @(negedge clk);
        check("done_fall", 32'(bus.L2_done), 32'd0);
    endtask

    // L2_start dropped right after being sampled: done must pulse for exactly one cycle.
    task automatic do_short_req(input logic [7:0] addr, input logic we, input logic [7:0] wdata);
        logic hit, got;
        int   cyc;
        model_issue(addr, we, wdata, hit);
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        bus.L2_start  = 1'b1;
        @(negedge clk);
        bus.L2_start  = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            got = bus.L2_done;
        end
        check("short_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("short_done_pulse", 32'(bus.L2_done), 32'd0);
        repeat (3) @(negedge clk);
        check("short_no_restart", 32'(bus.L2_done), 32'd0);
    endtask

    // Backing memory: answers each request after mem_lat_cfg cycles, abandons on reset.
    initial begin
        mx_t  e;
        logic [7:0] a, d;
        logic w, aborted;
        int   lat;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req) begin
                a = bus.mem_addr;
                w = bus.mem_we;
                d = bus.mem_wdata;
                if (mx_q.size() == 0) begin
                    check("mem_unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = mx_q.pop_front();
                    check("mem_addr", 32'(a), 32'(e.addr));
                    check("mem_we", 32'(w), 32'(e.we));
                    if (e.we) check("mem_wdata", 32'(d), 32'(e.wdata));
                end
                lat = mem_lat_cfg;
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && rst_n) begin
                    if (w) mem[a] = d;
                    bus.mem_rdata = w ? 8'($urandom) : mem[a];
                    bus.mem_ack   = 1'b1;
                    @(negedge clk);
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Response monitor: each rising L2_done consumes one scoreboard entry.
    initial begin
        sb_t  e;
        logic prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.L2_done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_read) check("rdata", 32'(bus.rdata), 32'(e.data));
                end
            end
            prev_done = bus.L2_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h15]     = 8'hA7;
        ref_mem[8'h15] = 8'hA7;
        model_reset();
        bus.L2_start  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_we    = 1'b0;
        bus.req_wdata = 8'h00;
        rst_n = 1'b0;
        #1;
        check("rst_done", 32'(bus.L2_done), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        mem_lat_cfg = 3;
        do_req(8'h15, 1'b0, 8'h00, 2);   // miss, refill 0xA7
        do_req(8'h15, 1'b0, 8'h00, 0);   // hit
        do_req(8'h15, 1'b1, 8'h3C, 1);   // write-through hit
        do_req(8'h15, 1'b0, 8'h00, 0);   // hit, 0x3C
        do_req(8'h25, 1'b1, 8'h5A, 0);   // write miss, no allocate
        do_req(8'h15, 1'b0, 8'h00, 0);   // still hits
        do_req(8'h25, 1'b0, 8'h00, 0);   // conflict miss, evicts 0x15
        do_req(8'h15, 1'b0, 8'h00, 0);   // miss again
        do_req(8'h15, 1'b0, 8'h00, 10);  // long hold after done

        // Reset in the middle of a memory read.
        mem_lat_cfg = 20;
        begin
            mx_t m;
            m.addr = 8'h2A; m.we = 1'b0; m.wdata = 8'h00;
            mx_q.push_back(m);
        end
        bus.req_addr = 8'h2A;
        bus.req_we   = 1'b0;
        bus.L2_start = 1'b1;
        cyc = 0;
        while (!bus.mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_mem_req_seen", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_done", 32'(bus.L2_done), 32'd0);
        check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mid_mem_addr", 32'(bus.mem_addr), 32'd0);
        bus.L2_start = 1'b0;
        sb_q.delete();
        mx_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_lat_cfg = 3;
        @(negedge clk);
        do_req(8'h15, 1'b0, 8'h00, 0);   // valid bits cleared: miss

        for (int i = 0; i < 60; i++) begin
            mem_lat_cfg = $urandom_range(0, 4);
            do_req(8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                   8'($urandom), $urandom_range(0, 3));
        end

        mem_lat_cfg = 2;
        do_short_req(8'h06, 1'b1, 8'hC3);
        do_short_req(8'h06, 1'b0, 8'h00);

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("mem_q_drained", mx_q.size(), 32'd0);
`ifdef L2_STATS_EN
        check("hit_cnt", 32'(hit_cnt), n_hit);
        check("miss_cnt", 32'(miss_cnt), n_miss);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
